// File: rtl/instruction_fetch.sv
// Instruction fetch: PC, IR and the FETCH/EXEC handshake with instruction memory.
// Define PC_ALIGN_CHECK_EN to trap misaligned next-PC targets into a sticky fault.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  PCselect,
   input  logic        Branch,
   input  logic        zero,
   input  logic [31:0] jr_addr,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_valid,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic [5:0]  func,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fault
);

   typedef enum logic {
      S_FETCH = 1'b0,
      S_EXEC  = 1'b1
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_ir;

   logic [31:0] w_pc_plus4;
   logic [31:0] w_br_off;
   logic [31:0] w_br_tgt;
   logic [31:0] w_j_tgt;
   logic [31:0] w_next_pc;

   assign w_pc_plus4 = r_pc + 32'd4;
   assign w_br_off   = {{14{r_ir[15]}}, r_ir[15:0], 2'b00};
   assign w_br_tgt   = w_pc_plus4 + w_br_off;
   assign w_j_tgt    = {w_pc_plus4[31:28], r_ir[25:0], 2'b00};

   always_comb begin
      w_next_pc = w_pc_plus4;
      case (PCselect)
         2'b00:   w_next_pc = (Branch && zero) ? w_br_tgt : w_pc_plus4;
         2'b01:   w_next_pc = w_j_tgt;
         2'b10:   w_next_pc = jr_addr;
         default: w_next_pc = w_pc_plus4;
      endcase
   end

`ifdef PC_ALIGN_CHECK_EN
   logic r_fault;
   logic w_misalign;

   assign w_misalign = (w_next_pc[1:0] != 2'b00);
   assign fault      = r_fault;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_FETCH;
         r_pc    <= RESET_PC;
         r_ir    <= 32'h0;
         r_fault <= 1'b0;
      end else begin
         unique case (r_state)
            S_FETCH: begin
               if (imem_valid) begin
                  r_ir    <= imem_rdata;
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (!stall) begin
                  r_state <= S_FETCH;
                  // A bad target keeps pc, so the same instruction is refetched.
                  if (w_misalign) r_fault <= 1'b1;
                  else            r_pc    <= w_next_pc;
               end
            end
         endcase
      end
   end
`else
   assign fault = 1'b0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_FETCH;
         r_pc    <= RESET_PC;
         r_ir    <= 32'h0;
      end else begin
         unique case (r_state)
            S_FETCH: begin
               if (imem_valid) begin
                  r_ir    <= imem_rdata;
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (!stall) begin
                  r_state <= S_FETCH;
                  r_pc    <= w_next_pc;
               end
            end
         endcase
      end
   end
`endif

   assign imem_req    = (r_state == S_FETCH) && !rst;
   assign instr_valid = (r_state == S_EXEC) && !rst;
   assign imem_addr   = r_pc;
   assign pc          = r_pc;
   assign pc_plus4    = w_pc_plus4;
   assign instr       = r_ir;
   assign opcode      = r_ir[31:26];
   assign func        = r_ir[5:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random traffic
// checked every cycle against a plain behavioural model.
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  PCselect;
   logic        Branch;
   logic        zero;
   logic [31:0] jr_addr;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_valid;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [5:0]  func;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fault;

   int ntests = 0;
   int nfail  = 0;

   // reference model state
   logic [31:0] m_pc;
   logic [31:0] m_ir;
   bit          m_exec;
   bit          m_fault;
   bit          m_rst;

   always #5 clk = ~clk;

   instruction_fetch #(.RESET_PC(32'h0)) dut (
      .clk        (clk),
      .rst        (rst),
      .PCselect   (PCselect),
      .Branch     (Branch),
      .zero       (zero),
      .jr_addr    (jr_addr),
      .stall      (stall),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .imem_valid (imem_valid),
      .instr      (instr),
      .opcode     (opcode),
      .func       (func),
      .instr_valid(instr_valid),
      .pc         (pc),
      .pc_plus4   (pc_plus4),
      .fault      (fault)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all();
      logic [31:0] e_pc4;
      e_pc4 = m_pc + 32'd4;
      chk("pc", pc, m_pc);
      chk("imem_addr", imem_addr, m_pc);
      chk("pc_plus4", pc_plus4, e_pc4);
      chk("instr", instr, m_ir);
      chk("opcode", 32'(opcode), 32'(m_ir[31:26]));
      chk("func", 32'(func), 32'(m_ir[5:0]));
      chk("instr_valid", 32'(instr_valid), 32'(m_exec && !m_rst));
      chk("imem_req", 32'(imem_req), 32'(!m_exec && !m_rst));
      chk("fault", 32'(fault), 32'(m_fault));
   endtask

   function automatic logic [31:0] model_next_pc(input logic [1:0] sel,
         input bit br, input bit z, input logic [31:0] jr);
      logic [31:0] p4;
      p4 = m_pc + 32'd4;
      if (sel == 2'd1) return {p4[31:28], m_ir[25:0], 2'b00};
      if (sel == 2'd2) return jr;
      if (sel == 2'd0 && br && z)
         return p4 + 32'($signed(m_ir[15:0])) * 32'sd4;
      return p4;
   endfunction

   task automatic step(input bit r, input logic [1:0] sel, input bit br,
                       input bit z, input logic [31:0] jr, input bit st,
                       input bit v, input logic [31:0] rd);
      logic [31:0] np;
      @(negedge clk);
      rst = r; PCselect = sel; Branch = br; zero = z;
      jr_addr = jr; stall = st; imem_valid = v; imem_rdata = rd;
      @(posedge clk);
      m_rst = r;
      if (r) begin
         m_pc = 32'h0; m_ir = 32'h0; m_exec = 0; m_fault = 0;
      end else if (!m_exec) begin
         if (v) begin
            m_ir = rd; m_exec = 1;
         end
      end else if (!st) begin
         np = model_next_pc(sel, br, z, jr);
         m_exec = 0;
`ifdef PC_ALIGN_CHECK_EN
         if (np[1:0] != 2'b00) m_fault = 1;
         else m_pc = np;
`else
         m_pc = np;
`endif
      end
      #1;
      chk_all();
   endtask

   task automatic fetch(input logic [31:0] w);
      step(0, 2'd0, 0, 0, 32'h0, 0, 1, w);
   endtask

   task automatic exec(input logic [1:0] sel, input bit br, input bit z,
                       input logic [31:0] jr);
      step(0, sel, br, z, jr, 0, 0, 32'h0);
   endtask

   initial begin
      rst = 1; PCselect = 0; Branch = 0; zero = 0; jr_addr = 0;
      stall = 0; imem_valid = 0; imem_rdata = 0;
      m_pc = 0; m_ir = 0; m_exec = 0; m_fault = 0; m_rst = 1;

      step(1, 2'd0, 0, 0, 32'h0, 0, 0, 32'h0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_instr", instr, 32'h0);
      step(0, 2'd0, 0, 0, 32'h0, 0, 0, 32'h0);
      chk("req_after_rst", 32'(imem_req), 32'd1);

      fetch(32'h0000_0020);
      chk("first_valid", 32'(instr_valid), 32'd1);
      chk("first_func", 32'(func), 32'd32);
      exec(2'd0, 0, 0, 32'h0);
      chk("seq_pc4", pc, 32'h4);

      fetch(32'h0);
      exec(2'd2, 0, 0, 32'h8);
      fetch(32'h1000_FFFF);
      exec(2'd0, 1, 1, 32'h0);
      chk("beq_taken", pc, 32'h8);
      fetch(32'h1000_FFFF);
      exec(2'd0, 1, 0, 32'h0);
      chk("beq_not_taken", pc, 32'hC);

      fetch(32'h0);
      exec(2'd2, 0, 0, 32'h1000_0000);
      fetch(32'h0800_0010);
      exec(2'd1, 0, 0, 32'h0);
      chk("jump", pc, 32'h1000_0040);
      fetch(32'h0800_0010);
      exec(2'd2, 0, 0, 32'h0000_0100);
      chk("jr", pc, 32'h100);

      fetch(32'h0000_0020);
      for (int i = 0; i < 3; i++) begin
         step(0, 2'd0, 0, 0, 32'h0, 1, 1, 32'hDEAD_BEEF);
         chk("stall_pc", pc, 32'h100);
         chk("stall_instr", instr, 32'h20);
      end
      exec(2'd0, 0, 0, 32'h0);
      chk("stall_release", pc, 32'h104);

      step(1, 2'd0, 0, 0, 32'h0, 0, 1, 32'hDEAD_BEEF);
      chk("rst_fetch_pc", pc, 32'h0);
      chk("rst_fetch_ir", instr, 32'h0);
      fetch(32'h0000_1234);
      chk("late_resp", instr, 32'h1234);

      exec(2'd2, 0, 0, 32'hFFFF_FFFC);
      fetch(32'h0);
      chk("wrap_pc4", pc_plus4, 32'h0);
      exec(2'd0, 0, 0, 32'h0);
      chk("wrap_pc", pc, 32'h0);

      fetch(32'h0);
      exec(2'd2, 0, 0, 32'h0000_0102);
`ifdef PC_ALIGN_CHECK_EN
      chk("align_fault", 32'(fault), 32'd1);
      chk("align_pc_hold", pc, 32'h0);
      chk("align_refetch", 32'(imem_req), 32'd1);
      fetch(32'h0);
      exec(2'd0, 0, 0, 32'h0);
      chk("fault_sticky", 32'(fault), 32'd1);
      step(1, 2'd0, 0, 0, 32'h0, 0, 0, 32'h0);
      chk("fault_clear", 32'(fault), 32'd0);
`else
      chk("noalign_pc", pc, 32'h102);
      chk("noalign_fault", 32'(fault), 32'd0);
      step(1, 2'd0, 0, 0, 32'h0, 0, 0, 32'h0);
`endif

      for (int i = 0; i < 400; i++) begin
         logic [31:0] jr;
         jr = $urandom;
         if ($urandom_range(0, 7) != 0) jr[1:0] = 2'b00;
         step($urandom_range(0, 49) == 0, 2'($urandom), 1'($urandom),
              1'($urandom), jr, $urandom_range(0, 3) == 0,
              $urandom_range(0, 2) != 0, $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 PCselect  input  2  next-PC source from controller: 00 sequential/branch, 01 jump (j/jal), 10 register (jr), 11 reserved.
REQ-005 Branch  input  1  controller branch-instruction flag.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 jr_addr  input  32  register-file rs value, the jr target.
REQ-008 stall  input  1  downstream hold; freezes PC and IR in EXEC.
REQ-009 imem_req  output  1  instruction-memory read request.
REQ-010 imem_addr  output  32  read address, always equal to pc.
REQ-011 imem_rdata  input  32  instruction word, valid when imem_valid=1.
REQ-012 imem_valid  input  1  memory response strobe.
REQ-013 instr  output  32  instruction register (IR).
REQ-014 opcode  output  6  IR[31:26], to controller.
REQ-015 func  output  6  IR[5:0], to controller.
REQ-016 instr_valid  output  1  IR holds the instruction currently executing.
REQ-017 pc  output  32  current program counter.
REQ-018 pc_plus4  output  32  pc+4, link value for jal.
REQ-019 fault  output  1  sticky misaligned-target flag (tied 0 without PC_ALIGN_CHECK_EN).

Function
REQ-020 Two-state FSM, FETCH and EXEC; instr_valid=1 exactly in EXEC; imem_req=1 exactly in FETCH and not in reset.
REQ-021 FETCH: imem_valid=1 at an edge loads IR from imem_rdata and moves to EXEC; otherwise stays in FETCH, IR unchanged.
REQ-022 Minimum latency: imem_valid in first FETCH cycle gives instr_valid on the next cycle; one instruction per two cycles at best.
REQ-023 EXEC with stall=0: pc loads next_pc, FSM returns to FETCH; EXEC with stall=1: pc, IR, state held.
REQ-024 imem_valid while in EXEC is ignored.
REQ-025 Branch target = pc_plus4 + (sign-extended IR[15:0] << 2), modulo 2^32.
REQ-026 Jump target = {pc_plus4[31:28], IR[25:0], 2'b00}.
REQ-027 next_pc: PCselect=01 jump target; 10 jr_addr; 00 branch target if Branch=1 and zero=1, else pc_plus4; 11 pc_plus4.
REQ-028 pc_plus4 = pc+4 modulo 2^32; pc 32'hFFFFFFFC sequentially wraps to 32'h00000000.
REQ-029 opcode, func, imem_addr, pc_plus4 are combinational from IR/pc.

Reset
REQ-030 rst=1 at an edge: pc=RESET_PC, IR=0, state=FETCH, fault=0, regardless of state, stall, or imem_valid that cycle.
REQ-031 During rst, imem_req=0 and instr_valid=0; first request issues the cycle after rst deasserts.
REQ-032 Reset mid-fetch abandons the outstanding fetch; a late imem_valid arriving after reset is treated as response to the new RESET_PC request.

Configuration
REQ-033 Macro PC_ALIGN_CHECK_EN defined: in EXEC with stall=0, a next_pc with bits [1:0]!=0 sets fault, pc holds its value, FSM goes to FETCH (refetches same instruction); fault clears only on reset.
REQ-034 Macro PC_ALIGN_CHECK_EN undefined: no check, next_pc loaded unmodified, fault constant 0.

Verification
REQ-035 rst 1 cycle, imem_valid=1 with 32'h00000020 -> imem_addr=0, next cycle instr_valid=1, opcode=0, func=32, then pc=4.
REQ-036 pc=8, IR=32'h1000FFFF (beq, off -1), PCselect=00, Branch=1, zero=1 -> pc=8; same with zero=0 -> pc=12.
REQ-037 pc=32'h10000000, IR=32'h08000010 (j), PCselect=01 -> pc=32'h10000040; PCselect=10, jr_addr=32'h00000100 -> pc=32'h00000100.
REQ-038 EXEC with stall=1 for 3 cycles -> pc, instr, instr_valid=1 unchanged; stall drop -> pc advances one cycle later; rst asserted during FETCH with imem_valid=1 -> pc=RESET_PC, instr=0.
REQ-039 pc=32'hFFFFFFFC, PCselect=00, Branch=0 -> pc=0, pc_plus4 before update 0.
REQ-040 PC_ALIGN_CHECK_EN set, PCselect=10, jr_addr=32'h00000102 -> fault=1, pc unchanged, imem_req=1 next cycle; fault stays 1 until rst.
